// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte buffer and launch sequencer that sits directly in front of the UART
//   transmitter. Producers push bytes through a valid/ready handshake into a
//   circular FIFO. A small FSM then hands the bytes to the transmitter one at
//   a time. Each byte is a one-cycle uart_tx_en pulse with uart_tx_data held
//   until the next launch. Only one byte is ever in flight: after a launch the
//   FSM waits for busy to rise and then fall before it launches again.
//
//   Optional feature: define UART_TX_FIFO_OVF_EN to add overflow detection.
//   This adds the ports ovf_sticky (out) and ovf_clr (in).
//
// Ports
//   clk           in   1             system clock, rising edge
//   rst_n         in   1             asynchronous reset, active low
//   in_valid      in   1             producer has a byte on in_data
//   in_data       in   8             byte to enqueue
//   in_ready      out  1             FIFO can accept (= !fifo_full)
//   uart_tx_busy  in   1             transmitter busy flag
//   uart_tx_en    out  1             one-cycle launch pulse
//   uart_tx_data  out  8             byte presented with uart_tx_en
//   fifo_empty    out  1             FIFO holds no entries
//   fifo_full     out  1             FIFO holds 2**DEPTH_LOG2 entries
//   fifo_level    out  DEPTH_LOG2+1  current entry count
//   ovf_sticky    out  1             (UART_TX_FIFO_OVF_EN) a write was dropped
//   ovf_clr       in   1             (UART_TX_FIFO_OVF_EN) clear ovf_sticky
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  uart_tx_busy,
  output logic                  uart_tx_en,
  output logic [7:0]            uart_tx_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_level
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
`endif
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t                  state;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    wr_en;
  logic                    pop;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign in_ready   = !fifo_full;

  // Writes while full are dropped. fifo_empty comes from the registered
  // level, so a byte written on an edge can only be popped on a later edge.
  assign wr_en = in_valid && !fifo_full;
  assign pop   = (state == S_IDLE) && !fifo_empty && !uart_tx_busy;

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Launch sequencer. After a launch it waits for a full busy rise/fall
  // cycle before it returns to idle. This keeps at most one byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx_en <= 1'b0;
          if (pop) begin
            uart_tx_data <= mem[rd_ptr];
            uart_tx_en   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          uart_tx_en <= 1'b0;
          state      <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (uart_tx_busy) begin
            state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!uart_tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          uart_tx_en <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // A dropped byte sets the flag. If a set and a clear land on the same
  // edge, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (in_valid && fifo_full) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with DEPTH_LOG2=2 (4 entries).
//   A small transmitter model raises busy the cycle after each launch and
//   holds it for a few cycles. force_busy lets the bench keep the
//   transmitter busy for the full/wrap scenarios.
module tb_uart_tx_fifo;

  localparam int DL2      = 2;
  localparam int BUSY_LEN = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           uart_tx_busy;
  logic           uart_tx_en;
  logic [7:0]     uart_tx_data;
  logic           fifo_empty;
  logic           fifo_full;
  logic [DL2:0]   fifo_level;
`ifdef UART_TX_FIFO_OVF_EN
  logic           ovf_sticky;
  logic           ovf_clr;
`endif

  logic           mdl_busy;
  logic           force_busy;
  logic           pend;
  logic           en_prev;
  logic           busy_neg;
  int             cnt;
  logic [7:0]     got_q[$];

  int             n_chk;
  int             n_err;

  assign uart_tx_busy = mdl_busy | force_busy;

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // busy as the DUT sees it at the next rising edge
  always @(negedge clk) busy_neg = uart_tx_busy;

  // Transmitter model and launch monitor
  initial begin
    mdl_busy = 1'b0;
    pend     = 1'b0;
    en_prev  = 1'b0;
    cnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mdl_busy = 1'b0;
        pend     = 1'b0;
        en_prev  = 1'b0;
        cnt      = 0;
      end else begin
        if (uart_tx_en) begin
          got_q.push_back(uart_tx_data);
          check("busy_at_launch", 32'(busy_neg), 0);
          check("en_one_cycle", 32'(en_prev), 0);
        end
        if (pend) begin
          mdl_busy = 1'b1;
          cnt      = BUSY_LEN;
        end else if (mdl_busy) begin
          if (cnt > 0) cnt--;
          else mdl_busy = 1'b0;
        end
        pend    = uart_tx_en;
        en_prev = uart_tx_en;
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int limit);
    int c;
    c = 0;
    while (got_q.size() < n && c < limit) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("launch_count", 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    force_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr    = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 32'(uart_tx_en), 0);
    check("rst_data", 32'(uart_tx_data), 32'h00);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ready", 32'(in_ready), 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_ovf", 32'(ovf_sticky), 0);
`endif
    rst_n = 1'b1;
    settle(2);

    // Single byte: written at edge N, launched at edge N+1
    got_q.delete();
    wr(8'hA5);
    check("single_lvl_wr", 32'(fifo_level), 1);
    check("single_en_early", 32'(uart_tx_en), 0);
    settle(1);
    check("single_en", 32'(uart_tx_en), 1);
    check("single_data", 32'(uart_tx_data), 32'hA5);
    check("single_lvl_pop", 32'(fifo_level), 0);
    settle(1);
    check("single_en_low", 32'(uart_tx_en), 0);
    check("single_data_hold", 32'(uart_tx_data), 32'hA5);
    settle(12);
    check("single_count", 32'(got_q.size()), 1);

    // Burst ordering
    got_q.delete();
    for (int i = 1; i <= 5; i++) wr(8'(i));
    wait_launches(5, 200);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check("burst_order", 32'(got_q[i]), 32'(i + 1));
    settle(12);
    check("burst_empty", 32'(fifo_empty), 1);

    // Full and pointer wrap with the transmitter held busy
    for (int r = 0; r < 3; r++) begin
      force_busy = 1'b1;
      settle(1);
      got_q.delete();
      for (int i = 0; i < 5; i++) begin
        wr(8'(8'h10 * (r + 1) + i));
        if (i < 3) check("fill_level", 32'(fifo_level), 32'(i + 1));
        if (i == 3) begin
          check("fill_full", 32'(fifo_full), 1);
          check("fill_ready", 32'(in_ready), 0);
        end
      end
      check("drop_level", 32'(fifo_level), 4);
      check("drop_full", 32'(fifo_full), 1);
      check("held_no_launch", 32'(got_q.size()), 0);
      force_busy = 1'b0;
      wait_launches(4, 200);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
        check("wrap_order", 32'(got_q[i]), 32'(8'h10 * (r + 1) + i));
      settle(12);
      check("wrap_empty", 32'(fifo_empty), 1);
      check("wrap_count", 32'(got_q.size()), 4);
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Overflow flag: set, clear, and set winning over a same-edge clear
    force_busy = 1'b1;
    settle(1);
    got_q.delete();
    for (int i = 0; i < 4; i++) wr(8'(8'h60 + i));
    check("ovf_before", 32'(ovf_sticky), 0);
    wr(8'hEE);
    check("ovf_set", 32'(ovf_sticky), 1);
    ovf_clr = 1'b1;
    settle(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_sticky), 0);
    ovf_clr  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEF;
    settle(1);
    ovf_clr  = 1'b0;
    in_valid = 1'b0;
    check("ovf_set_wins", 32'(ovf_sticky), 1);
    check("ovf_level", 32'(fifo_level), 4);
    force_busy = 1'b0;
    wait_launches(4, 200);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("ovf_order", 32'(got_q[i]), 32'(8'h60 + i));
    settle(12);
`endif

    // Reset mid-frame in S_WAIT_LO with three bytes queued
    got_q.delete();
    for (int i = 0; i < 4; i++) wr(8'(8'hC1 + i));
    settle(1);
    check("mid_level", 32'(fifo_level), 3);
    check("mid_launched", 32'(got_q.size()), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_en", 32'(uart_tx_en), 0);
    check("mid_rst_empty", 32'(fifo_empty), 1);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_data", 32'(uart_tx_data), 32'h00);
    settle(2);
    rst_n = 1'b1;
    got_q.delete();
    settle(10);
    check("post_rst_no_launch", 32'(got_q.size()), 0);
    check("post_rst_level", 32'(fifo_level), 0);
    wr(8'h5A);
    wait_launches(1, 50);
    if (got_q.size() > 0) check("post_rst_data", 32'(got_q[0]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
